// File: rtl/delay_line_sensor_pkg.sv
// -----------------------------------------------------------------------------
// delay_line_sensor_pkg
// Shared types and helpers for the tapped delay-line sensor.
//   state_e        : measurement FSM states
//   POPCOUNT_MAX_W : widest match vector popcount() accepts
//   popcount()     : number of set bits in a (zero-extended) match vector
// -----------------------------------------------------------------------------
package delay_line_sensor_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    CAPTURE = 3'd2,
    EVAL    = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Callers zero-extend their tap vector to this width; upper bits stay 0
  // and collapse away in synthesis.
  localparam int unsigned POPCOUNT_MAX_W = 256;

  function automatic int unsigned popcount(input logic [POPCOUNT_MAX_W-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
      if (v[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/delay_line_sensor_chain.sv
// -----------------------------------------------------------------------------
// singlepath_2 / delay_line_chain
// singlepath_2     : one non-inverting delay stage (a_i -> y_o).
// delay_line_chain : NUM_STAGES singlepath_2 stages in series. Every stage
//                    net and instance is kept so synthesis cannot collapse
//                    the chain into a wire.
//   launch_i           in  1           edge injected into stage 0
//   stage_o            out NUM_STAGES  output of every stage, stage 0 first
// -----------------------------------------------------------------------------
module singlepath_2 (
  input  logic a_i,
  output logic y_o
);
  assign y_o = a_i;
endmodule

module delay_line_chain #(
  parameter int NUM_STAGES = 99
) (
  input  logic                  launch_i,
  output logic [NUM_STAGES-1:0] stage_o
);

  // Each stage owns separate nets so the chain is a plain series of wires
  // rather than a vector feeding back into itself.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    (* keep *) logic stage_in;
    (* keep *) logic stage_out;

    if (k == 0) begin : g_first
      assign stage_in = launch_i;
    end else begin : g_next
      assign stage_in = g_stage[k-1].stage_out;
    end

    (* keep *) singlepath_2 u_stage (
      .a_i (stage_in),
      .y_o (stage_out)
    );

    assign stage_o[k] = stage_out;
  end

endmodule

// File: rtl/delay_line_sensor.sv
// -----------------------------------------------------------------------------
// delay_line_sensor
// Launches a toggling edge into a kept delay chain, captures NUM_TAPS taps one
// clock later, counts the taps the edge reached (popcount, so bubbles in the
// thermometer code are tolerated) and sums NUM_SAMPLES such counts. The total
// is offered on a valid/ready handshake.
//
// Ports
//   clk           in  1        clock
//   rst           in  1        asynchronous reset, active high
//   start         in  1        request a measurement (only seen in IDLE)
//   busy          out 1        high in every state except IDLE
//   test_en       in  1        use test_taps as the match vector
//   test_taps     in  NUM_TAPS injected match vector (1 = tap propagated)
//   sample_valid  out 1        one-cycle pulse per evaluated sample
//   sample_count  out COUNT_W  popcount of that sample
//   result_valid  out 1        accumulated result available
//   result_ready  in  1        consumer takes the result
//   result        out ACC_W    sum over NUM_SAMPLES samples
//
// Optional build macro DELAY_LINE_SENSOR_MINMAX_EN adds:
//   min_count     out COUNT_W  smallest sample count of the run
//   max_count     out COUNT_W  largest sample count of the run
// -----------------------------------------------------------------------------
module delay_line_sensor
  import delay_line_sensor_pkg::*;
#(
  parameter  int NUM_STAGES  = 99,
  parameter  int NUM_TAPS    = 32,
  parameter  int TAP_OFFSET  = 0,
  parameter  int TAP_STRIDE  = 3,
  parameter  int NUM_SAMPLES = 16,
  localparam int COUNT_W     = $clog2(NUM_TAPS + 1),
  localparam int ACC_W       = COUNT_W + ((NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 0)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  input  logic                test_en,
  input  logic [NUM_TAPS-1:0] test_taps,
  output logic                sample_valid,
  output logic [COUNT_W-1:0]  sample_count,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [ACC_W-1:0]    result
`ifdef DELAY_LINE_SENSOR_MINMAX_EN
  ,
  output logic [COUNT_W-1:0]  min_count,
  output logic [COUNT_W-1:0]  max_count
`endif
);

  localparam int SCNT_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (TAP_OFFSET + (NUM_TAPS - 1) * TAP_STRIDE >= NUM_STAGES) begin : g_bad_taps
    $error("delay_line_sensor: last tap lies beyond the end of the chain");
  end
  if (NUM_SAMPLES < 1) begin : g_bad_samples
    $error("delay_line_sensor: NUM_SAMPLES must be at least 1");
  end
  if (NUM_TAPS > POPCOUNT_MAX_W) begin : g_bad_width
    $error("delay_line_sensor: NUM_TAPS exceeds POPCOUNT_MAX_W");
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e                state_q;
  logic                  launch_q;
  logic [NUM_TAPS-1:0]   cap_q;
  logic [ACC_W-1:0]      acc_q;
  logic [SCNT_W-1:0]     sample_cnt_q;
  logic                  busy_q;
  logic                  sample_valid_q;
  logic [COUNT_W-1:0]    sample_count_q;
  logic                  result_valid_q;
  logic [ACC_W-1:0]      result_q;

  // ---------------------------------------------------------------------------
  // Delay chain and tap selection
  // ---------------------------------------------------------------------------
  logic [NUM_STAGES-1:0] stage_out;
  logic [NUM_TAPS-1:0]   taps;

  delay_line_chain #(
    .NUM_STAGES (NUM_STAGES)
  ) u_chain (
    .launch_i (launch_q),
    .stage_o  (stage_out)
  );

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    taps = '0;
    for (int t = 0; t < NUM_TAPS; t++) begin
      taps[t] = stage_out[TAP_OFFSET + t * TAP_STRIDE];
    end
  end

  // Stages between taps are observed only so they do not read as dead logic.
  logic unused_stages;
  assign unused_stages = ^stage_out;

  // ---------------------------------------------------------------------------
  // Match vector and per-sample count
  // ---------------------------------------------------------------------------
  // A tap matches when the captured level equals the launched level, i.e. the
  // new edge had already reached it at the capture edge.
  logic [NUM_TAPS-1:0]       match;
  logic [POPCOUNT_MAX_W-1:0] match_ext;
  logic [COUNT_W-1:0]        pop_d;
  logic [ACC_W-1:0]          acc_d;
  logic                      last_sample;

  always_comb begin
    match     = test_en ? test_taps : ~(cap_q ^ {NUM_TAPS{launch_q}});
    match_ext = '0;
    match_ext[NUM_TAPS-1:0] = match;
  end

  assign pop_d       = COUNT_W'(popcount(match_ext));
  assign acc_d       = acc_q + ACC_W'(pop_d);
  assign last_sample = (sample_cnt_q == SCNT_W'(NUM_SAMPLES - 1));

  // ---------------------------------------------------------------------------
  // Measurement FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      launch_q       <= 1'b0;
      cap_q          <= '0;
      acc_q          <= '0;
      sample_cnt_q   <= '0;
      busy_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_count_q <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
    end else begin
      sample_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LAUNCH;
            busy_q  <= 1'b1;
          end
        end
        LAUNCH: begin
          // Alternate polarity so each launch produces a fresh edge.
          launch_q <= ~launch_q;
          state_q  <= CAPTURE;
        end
        CAPTURE: begin
          cap_q   <= taps;
          state_q <= EVAL;
        end
        EVAL: begin
          sample_count_q <= pop_d;
          sample_valid_q <= 1'b1;
          acc_q          <= acc_d;
          if (last_sample) begin
            sample_cnt_q   <= '0;
            result_q       <= acc_d;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end else begin
            sample_cnt_q <= sample_cnt_q + SCNT_W'(1);
            state_q      <= LAUNCH;
          end
        end
        DONE: begin
          // Result is held unchanged until the consumer takes it.
          if (result_ready) begin
            acc_q          <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign sample_valid = sample_valid_q;
  assign sample_count = sample_count_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;

`ifdef DELAY_LINE_SENSOR_MINMAX_EN
  // ---------------------------------------------------------------------------
  // Per-run min/max of the sample counts; the first sample of a run reloads
  // both so nothing carries over from the previous run.
  // ---------------------------------------------------------------------------
  logic [COUNT_W-1:0] min_q;
  logic [COUNT_W-1:0] max_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else if (state_q == EVAL) begin
      if (sample_cnt_q == '0) begin
        min_q <= pop_d;
        max_q <= pop_d;
      end else begin
        if (pop_d < min_q) min_q <= pop_d;
        if (pop_d > max_q) max_q <= pop_d;
      end
    end
  end

  assign min_count = min_q;
  assign max_count = max_q;
`endif

endmodule

// File: tb/tb_delay_line_sensor.sv
// -----------------------------------------------------------------------------
// tb_delay_line_sensor
// Two instances share one clock:
//   dut8    : NUM_TAPS=8, NUM_SAMPLES=4, driven through test_taps
//   dut_def : default parameters, real chain (test_en=0)
// Expected values are hand-computed constants in a run table plus a few
// directed sequences (reset mid-run, backpressure, start while busy).
// -----------------------------------------------------------------------------
module tb_delay_line_sensor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // dut8: 8 taps, 4 samples -> COUNT_W=4, ACC_W=6
  // ---------------------------------------------------------------------------
  logic       rst8, start8, busy8, test_en8, sample_valid8, result_valid8, result_ready8;
  logic [7:0] test_taps8;
  logic [3:0] sample_count8;
  logic [5:0] result8;
`ifdef DELAY_LINE_SENSOR_MINMAX_EN
  logic [3:0] min8, max8;
`endif

  delay_line_sensor #(
    .NUM_STAGES  (99),
    .NUM_TAPS    (8),
    .TAP_OFFSET  (0),
    .TAP_STRIDE  (3),
    .NUM_SAMPLES (4)
  ) dut8 (
    .clk          (clk),
    .rst          (rst8),
    .start        (start8),
    .busy         (busy8),
    .test_en      (test_en8),
    .test_taps    (test_taps8),
    .sample_valid (sample_valid8),
    .sample_count (sample_count8),
    .result_valid (result_valid8),
    .result_ready (result_ready8),
    .result       (result8)
`ifdef DELAY_LINE_SENSOR_MINMAX_EN
    ,
    .min_count    (min8),
    .max_count    (max8)
`endif
  );

  // ---------------------------------------------------------------------------
  // dut_def: defaults -> COUNT_W=6, ACC_W=10
  // ---------------------------------------------------------------------------
  logic        rst_d, start_d, busy_d, test_en_d, sample_valid_d, result_valid_d, result_ready_d;
  logic [31:0] test_taps_d;
  logic [5:0]  sample_count_d;
  logic [9:0]  result_d;
`ifdef DELAY_LINE_SENSOR_MINMAX_EN
  logic [5:0]  min_d, max_d;
`endif

  delay_line_sensor dut_def (
    .clk          (clk),
    .rst          (rst_d),
    .start        (start_d),
    .busy         (busy_d),
    .test_en      (test_en_d),
    .test_taps    (test_taps_d),
    .sample_valid (sample_valid_d),
    .sample_count (sample_count_d),
    .result_valid (result_valid_d),
    .result_ready (result_ready_d),
    .result       (result_d)
`ifdef DELAY_LINE_SENSOR_MINMAX_EN
    ,
    .min_count    (min_d),
    .max_count    (max_d)
`endif
  );

  // ---------------------------------------------------------------------------
  // Run table for dut8: per-sample injected taps and hand-computed results
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0][7:0] taps;     // taps[s] injected for sample s
    logic [3:0][3:0] exp_cnt;  // expected sample_count for sample s
    logic [5:0]      exp_res;
    logic [3:0]      exp_min;
    logic [3:0]      exp_max;
  } run_t;

  run_t runs [4];

  function automatic run_t mk(input logic [7:0] t0, t1, t2, t3,
                              input logic [3:0] c0, c1, c2, c3,
                              input logic [5:0] res,
                              input logic [3:0] mn, mx);
    run_t r;
    r.taps[0] = t0; r.taps[1] = t1; r.taps[2] = t2; r.taps[3] = t3;
    r.exp_cnt[0] = c0; r.exp_cnt[1] = c1; r.exp_cnt[2] = c2; r.exp_cnt[3] = c3;
    r.exp_res = res;
    r.exp_min = mn;
    r.exp_max = mx;
    return r;
  endfunction

  // Called #1 after a posedge with dut8 idle. Start is accepted at edge 0;
  // result_valid must rise at edge 12 together with the fourth sample pulse.
  task automatic run8(input run_t r, input bit start_in_launch);
    int  n_pulses;
    int  done_edge;
    test_taps8 = r.taps[0];
    start8     = 1'b1;
    @(posedge clk); #1;
    check("busy after start", int'(busy8), 1);
    if (!start_in_launch) start8 = 1'b0;
    n_pulses  = 0;
    done_edge = -1;
    for (int e = 1; e <= 40 && done_edge < 0; e++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      if (sample_valid8) begin
        if (n_pulses < 4) check("sample_count8", int'(sample_count8), int'(r.exp_cnt[n_pulses]));
        n_pulses++;
        if (n_pulses < 4) test_taps8 = r.taps[n_pulses];
      end
      if (result_valid8) done_edge = e;
    end
    check("result_valid8 edge", done_edge, 12);
    check("sample pulses8", n_pulses, 4);
    check("result8", int'(result8), int'(r.exp_res));
`ifdef DELAY_LINE_SENSOR_MINMAX_EN
    check("min_count8", int'(min8), int'(r.exp_min));
    check("max_count8", int'(max8), int'(r.exp_max));
`endif
  endtask

  task automatic accept8();
    result_ready8 = 1'b1;
    @(posedge clk); #1;
    result_ready8 = 1'b0;
    check("busy8 after accept", int'(busy8), 0);
    check("result_valid8 after accept", int'(result_valid8), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n_pulses;
    int done_edge;
    int exp_pol;

    runs[0] = mk(8'h0F, 8'h0F, 8'h0F, 8'h0F, 4'd4, 4'd4, 4'd4, 4'd4, 6'd16, 4'd4, 4'd4);
    runs[1] = mk(8'hFF, 8'h00, 8'h3C, 8'h81, 4'd8, 4'd0, 4'd4, 4'd2, 6'd14, 4'd0, 4'd8);
    runs[2] = mk(8'h01, 8'h03, 8'h07, 8'hFF, 4'd1, 4'd2, 4'd3, 4'd8, 6'd14, 4'd1, 4'd8);
    runs[3] = mk(8'hAA, 8'h55, 8'hF0, 8'h0F, 4'd4, 4'd4, 4'd4, 4'd4, 6'd16, 4'd4, 4'd4);

    rst8 = 1'b1; start8 = 1'b0; test_en8 = 1'b1; test_taps8 = '0; result_ready8 = 1'b0;
    rst_d = 1'b1; start_d = 1'b0; test_en_d = 1'b0; test_taps_d = '0; result_ready_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst8 = 1'b0; rst_d = 1'b0;
    @(posedge clk); #1;

    // Reset state of both instances
    check("reset busy8", int'(busy8), 0);
    check("reset sample_valid8", int'(sample_valid8), 0);
    check("reset result_valid8", int'(result_valid8), 0);
    check("reset result8", int'(result8), 0);
    check("reset busy_d", int'(busy_d), 0);
    check("reset result_d", int'(result_d), 0);

    // Table-driven runs, each accepted immediately
    for (int i = 0; i < 4; i++) begin
      run8(runs[i], 1'b0);
      accept8();
    end

    // Backpressure: DONE holds for 10 cycles, start pulse is ignored
    run8(runs[0], 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      check("hold result8", int'(result8), 16);
      check("hold result_valid8", int'(result_valid8), 1);
      check("hold busy8", int'(busy8), 1);
      check("hold sample_valid8", int'(sample_valid8), 0);
    end
    accept8();
    repeat (3) begin
      @(posedge clk); #1;
      check("no queued run busy8", int'(busy8), 0);
    end

    // start held into LAUNCH of a running measurement is ignored
    run8(runs[1], 1'b1);
    accept8();
    repeat (4) begin
      @(posedge clk); #1;
      check("idle after launch-start busy8", int'(busy8), 0);
    end

    // Default instance: reset after the fifth sample discards the run
    start_d = 1'b1;
    @(posedge clk); #1;
    start_d = 1'b0;
    n_pulses = 0;
    for (int e = 1; e <= 60 && n_pulses < 5; e++) begin
      @(posedge clk); #1;
      if (sample_valid_d) n_pulses++;
    end
    check("pulses before reset", n_pulses, 5);
    rst_d = 1'b1;
    #1;
    check("mid reset busy_d", int'(busy_d), 0);
    check("mid reset sample_valid_d", int'(sample_valid_d), 0);
    check("mid reset sample_count_d", int'(sample_count_d), 0);
    check("mid reset result_valid_d", int'(result_valid_d), 0);
    check("mid reset result_d", int'(result_d), 0);
    check("mid reset launch_q", int'(dut_def.launch_q), 0);
`ifdef DELAY_LINE_SENSOR_MINMAX_EN
    check("mid reset min_d", int'(min_d), 0);
    check("mid reset max_d", int'(max_d), 0);
`endif
    @(posedge clk); #1;
    rst_d = 1'b0;
    @(posedge clk); #1;

    // Fresh full run on the zero-delay chain: every tap is reached
    start_d = 1'b1;
    @(posedge clk); #1;
    start_d = 1'b0;
    n_pulses  = 0;
    done_edge = -1;
    for (int e = 1; e <= 100 && done_edge < 0; e++) begin
      @(posedge clk); #1;
      if (sample_valid_d) begin
        check("sample_count_d", int'(sample_count_d), 32);
        // launch_q starts at 0 and toggles once per sample: 1,0,1,0,...
        exp_pol = (n_pulses % 2 == 0) ? 1 : 0;
        check("launch polarity", int'(dut_def.launch_q), exp_pol);
        n_pulses++;
      end
      if (result_valid_d) done_edge = e;
    end
    check("result_valid_d edge", done_edge, 48);
    check("sample pulses_d", n_pulses, 16);
    check("result_d", int'(result_d), 512);
`ifdef DELAY_LINE_SENSOR_MINMAX_EN
    check("min_d", int'(min_d), 32);
    check("max_d", int'(max_d), 32);
`endif
    result_ready_d = 1'b1;
    @(posedge clk); #1;
    result_ready_d = 1'b0;
    check("busy_d after accept", int'(busy_d), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/delay_line_sensor.md
Name: delay_line_sensor

Overview:
Parametrised tapped delay-line sensor; the successor to the fixed 99-stage single-path chain.
- Launches a toggling edge into a kept chain of NUM_STAGES delay stages.
- Captures NUM_TAPS tap outputs one clock later and counts how far the edge propagated.
- Accumulates that count over NUM_SAMPLES launches and returns the total through a valid/ready handshake.
- Sits between the delay fabric and the spy readout logic.

Parameters:
NUM_STAGES, 99, number of chained delay stages.
NUM_TAPS, 32, number of captured tap points.
TAP_OFFSET, 0, stage index of tap 0.
TAP_STRIDE, 3, stage spacing between taps. Legal only if TAP_OFFSET+(NUM_TAPS-1)*TAP_STRIDE < NUM_STAGES (elaboration error otherwise).
NUM_SAMPLES, 16, launches per measurement. Must be >=1.

Ports:
clk  in  1  single clock.
rst  in  1  asynchronous reset, active-high.
start  in  1  request one measurement. Sampled only in IDLE.
busy  out  1  high in every state except IDLE.
test_en  in  1  replaces the hardware match vector with test_taps.
test_taps  in  NUM_TAPS  injected match vector, bit=1 means the tap propagated.
sample_valid  out  1  one-cycle pulse per evaluated sample.
sample_count  out  COUNT_W  popcount of the current sample. COUNT_W=$clog2(NUM_TAPS+1).
result_valid  out  1  accumulated result available.
result_ready  in  1  consumer accepts result.
result  out  ACC_W  sum over NUM_SAMPLES. ACC_W=COUNT_W+$clog2(NUM_SAMPLES), using +0 when NUM_SAMPLES=1.

Behaviour:
- Reset (asynchronous, any state): FSM=IDLE; launch_q, cap_q, acc, sample counter, busy, sample_valid, sample_count, result_valid and result all 0. Reset mid-measurement discards the run.
- Chain: stage 0 input is launch_q; stage k input is stage k-1 output. All chain nets and stage instances carry keep attributes.
- States:
  - IDLE: start=1 -> LAUNCH. start=0 -> stay.
  - LAUNCH: launch_q toggles on the exit edge -> CAPTURE.
  - CAPTURE: cap_q <= tap vector on the exit edge -> EVAL.
  - EVAL:
    - match = test_en ? test_taps : ~(cap_q ^ {NUM_TAPS{launch_q}}).
    - sample_count <= popcount(match); sample_valid pulses 1 cycle; acc <= acc + popcount(match).
    - If the sample counter equals NUM_SAMPLES-1: counter -> 0, go to DONE, result <= final sum. Otherwise increment the counter and go to LAUNCH.
  - DONE: result_valid=1, result stable. result_valid && result_ready -> IDLE, acc cleared, result_valid=0 on the next cycle.
- Popcount rather than first-zero search, so bubbles in the thermometer code are tolerated.
- Latency: start accepted at edge 0; result_valid rises after 3*NUM_SAMPLES edges.
- start is ignored while busy; no queuing.
- result_ready is ignored outside DONE.
- Backpressure: DONE holds indefinitely and result does not change.
- No overflow is possible: the maximum sum is NUM_TAPS*NUM_SAMPLES, which fits ACC_W.
- test_en may change at any time. It only affects the EVAL cycle in which it is sampled.

Optional Feature:
DELAY_LINE_SENSOR_MINMAX_EN
- Defined:
  - Adds outputs min_count and max_count, each COUNT_W bits, both 0 at reset.
  - Loaded from the first sample of each run, then updated in each EVAL.
  - Valid and stable together with result_valid.
- Undefined: the ports and tracking registers do not exist. All other behaviour is identical.

Decomposition:
- Package delay_line_sensor_pkg: state enum (IDLE, LAUNCH, CAPTURE, EVAL, DONE) and a popcount function.
- Sub-module delay_line_chain: generate-loop of NUM_STAGES singlepath_2 stages with kept nets; exposes the full stage-output vector, from which the parent selects the taps.
- Top holds the FSM, capture register, accumulator and handshake.

Test Plan:
1. Assert rst mid-run at sample 5, release -> all outputs 0, busy=0, the next start produces a full fresh run.
2. NUM_TAPS=8, NUM_SAMPLES=4, test_en=1, test_taps=8'h0F, pulse start -> four sample_valid pulses with sample_count=4; result_valid at edge 12 with result=16.
3. Same configuration, test_taps changed per sample to 8'hFF, 8'h00, 8'h3C, 8'h81 -> sample_count 8,0,4,2; result=14. With the macro defined: min_count=0, max_count=8.
4. Hold result_ready=0 for 10 cycles in DONE and pulse start meanwhile -> result stays 16, busy=1, no new run; result_ready=1 -> IDLE on the next cycle.
5. Pulse start during LAUNCH of a running measurement -> ignored; exactly NUM_SAMPLES sample_valid pulses occur.
6. Defaults, test_en=0, zero-delay simulation -> every sample_count=32 and result=512, with launch_q alternating polarity across samples.
